// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO with a drain controller that feeds uart_tx through
// the tx_start / tx_data / tx_busy handshake. Producers push at clock rate
// without watching the transmitter; bytes leave strictly in arrival order.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | tx_start low; pop and launch when data is held and tx idle
// S_START | tx_start held high until uart_tx reports busy
// S_DRAIN | tx_start low; wait for the frame in uart_tx to finish
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [ADDR_W:0]     r_level;
  logic                r_overflow;
  logic                r_tx_start;
  logic [7:0]          r_tx_data;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;

  // Fullness uses the pre-edge level, so a push while full is dropped even
  // if a pop happens on the same edge.
  assign w_full  = (r_level == LP_DEPTH);
  assign w_empty = (r_level == '0);
  assign w_push  = wr_en & ~w_full;

  // Next-state decode; a pop only ever happens on the IDLE->START transition.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && !tx_busy) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (tx_busy) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!tx_busy) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register plus the registered handshake outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_tx_start <= (w_state_nxt == S_START);
      if (w_pop) r_tx_data <= r_mem[r_rd_ptr];
    end
  end

  // Storage array; contents are don't-care after reset since level is zero.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  // Pointers, level counter and the dropped-push pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= wr_en & w_full;
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (ADDR_W+1)'(1);
        2'b01:   r_level <= r_level - (ADDR_W+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign full     = w_full;
  assign empty    = w_empty;
  assign level    = r_level;
  assign overflow = r_overflow;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: a behavioural uart_tx model consumes frames and
// compares each launched byte against a scoreboard filled at push time.
module tb_uart_tx_fifo;

  localparam int DEPTH      = 16;
  localparam int ADDR_W     = 4;
  localparam int BAUD_FRAME = 1042;  // 10 bits at 115200 baud from 12 MHz

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              wr_en = 1'b0;
  logic [7:0]        wr_data = 8'h00;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;

  logic              m_busy;
  logic              hold_busy = 1'b0;
  logic              m_ignore = 1'b0;
  int                m_cnt;
  int                frame_len = 8;
  int                rx_cnt = 0;
  logic [7:0]        sb[$];

  int                total = 0;
  int                bad = 0;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  assign tx_busy = m_busy | hold_busy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // uart_tx model: latches tx_data when it sees tx_start while idle.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (!m_busy) begin
      if (tx_start && !m_ignore && !hold_busy) begin
        m_busy <= 1'b1;
        m_cnt  <= frame_len;
        rx_cnt <= rx_cnt + 1;
        if (sb.size() == 0) chk("rx_unexpected", 32'(sb.size()), 32'd1);
        else                chk("rx_order", 32'(tx_data), 32'(sb.pop_front()));
      end
    end else begin
      if (m_cnt <= 1) m_busy <= 1'b0;
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic wait_rx(input int n, input int lim);
    int k = 0;
    while (rx_cnt < n && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("wait_rx", 32'(rx_cnt), 32'(n));
  endtask

  task automatic wait_busy(input logic v, input int lim);
    int k = 0;
    while (tx_busy !== v && k < lim) begin
      @(negedge clk);
      k++;
    end
    if (tx_busy !== v) chk("busy_wait", 32'(tx_busy), 32'(v));
  endtask

  initial begin
    int base;
    int peak;
    logic changed;

    // reset then idle
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("rst_empty",    32'(empty),    32'd1);
    chk("rst_full",     32'(full),     32'd0);
    chk("rst_level",    32'(level),    32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data",  32'(tx_data),  32'h00);
    chk("rst_overflow", 32'(overflow), 32'd0);
    changed = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (tx_start !== 1'b0 || empty !== 1'b1 || level !== '0 || overflow !== 1'b0 || tx_data !== 8'h00)
        changed = 1'b1;
    end
    chk("idle_stable", 32'(changed), 32'd0);

    // single byte latency and handshake
    frame_len = 8;
    @(posedge clk);
    #1 wr_en = 1'b1; wr_data = 8'h41; sb.push_back(8'h41);
    @(posedge clk);
    #1 wr_en = 1'b0;
    @(negedge clk);
    chk("single_empty_fall", 32'(empty),    32'd0);
    chk("single_start_pre",  32'(tx_start), 32'd0);
    @(negedge clk);
    chk("single_start",      32'(tx_start), 32'd1);
    chk("single_data",       32'(tx_data),  32'h41);
    chk("single_level",      32'(level),    32'd0);
    @(negedge clk);
    chk("single_busy_seen",  32'(tx_busy),  32'd1);
    chk("single_start_hold", 32'(tx_start), 32'd1);
    @(negedge clk);
    chk("single_start_drop", 32'(tx_start), 32'd0);
    wait_rx(1, 100);
    chk("single_end_empty",  32'(empty),    32'd1);

    // burst ordering at real baud timing
    frame_len = BAUD_FRAME;
    base = rx_cnt;
    peak = 0;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      #1 wr_en = 1'b1; wr_data = 8'(8'h30 + i); sb.push_back(8'(8'h30 + i));
      if (int'(level) > peak) peak = int'(level);
      @(posedge clk);
    end
    #1 wr_en = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (int'(level) > peak) peak = int'(level);
    end
    chk("burst_peak", 32'((peak == 9) || (peak == 10)), 32'd1);
    wait_rx(base + 10, 12000);
    repeat (BAUD_FRAME + 5) @(negedge clk);
    chk("burst_empty", 32'(empty), 32'd1);
    chk("burst_sb",    32'(sb.size()), 32'd0);

    // overflow with the transmitter held busy
    frame_len = 8;
    base = rx_cnt;
    @(posedge clk);
    #1 hold_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h50 + i);
      if (i < DEPTH) sb.push_back(8'(8'h50 + i));
      @(posedge clk);
      #1;
      if (i == 14) chk("ovf_not_full_15", 32'(full), 32'd0);
      if (i == 15) begin
        chk("ovf_full_16",   32'(full),     32'd1);
        chk("ovf_level_16",  32'(level),    32'(DEPTH));
        chk("ovf_no_pulse",  32'(overflow), 32'd0);
      end
      if (i == 16) begin
        chk("ovf_pulse",     32'(overflow), 32'd1);
        chk("ovf_level_17",  32'(level),    32'(DEPTH));
      end
    end
    wr_en = 1'b0;
    @(posedge clk);
    #1 chk("ovf_pulse_end", 32'(overflow), 32'd0);
    hold_busy = 1'b0;
    wait_rx(base + DEPTH, DEPTH * 20 + 50);
    repeat (20) @(negedge clk);
    chk("ovf_drained", 32'(empty), 32'd1);
    chk("ovf_sb",      32'(sb.size()), 32'd0);

    // wrap with simultaneous push and pop at level 15
    base = rx_cnt;
    @(posedge clk);
    #1 hold_busy = 1'b1;
    for (int i = 0; i < 15; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h60 + i); sb.push_back(8'(8'h60 + i));
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;
    @(posedge clk);
    #1 chk("wrap_fill", 32'(level), 32'd15);
    for (int i = 0; i < 40; i++) begin
      if (i == 0) begin
        hold_busy = 1'b0;
        wr_en = 1'b1; wr_data = 8'hA0; sb.push_back(8'hA0);
        @(posedge clk);
        #1 wr_en = 1'b0;
      end else begin
        wait_busy(1'b1, 50);
        wait_busy(1'b0, 50);
        @(posedge clk);
        #1 wr_en = 1'b1; wr_data = 8'(8'hA0 + i); sb.push_back(8'(8'hA0 + i));
        @(posedge clk);
        #1 wr_en = 1'b0;
      end
      @(negedge clk);
      chk("wrap_level", 32'(level),    32'd15);
      chk("wrap_ovf",   32'(overflow), 32'd0);
    end
    wait_rx(base + 55, 55 * 20 + 100);
    repeat (20) @(negedge clk);
    chk("wrap_empty", 32'(empty), 32'd1);

    // asynchronous reset while in START with level 5
    @(posedge clk);
    #1 m_ignore = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h70 + i); sb.push_back(8'(8'h70 + i));
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;
    chk("mid_start",  32'(tx_start), 32'd1);
    chk("mid_level",  32'(level),    32'd5);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_start", 32'(tx_start), 32'd0);
    chk("mid_rst_level", 32'(level),    32'd0);
    chk("mid_rst_empty", 32'(empty),    32'd1);
    chk("mid_rst_data",  32'(tx_data),  32'h00);
    sb.delete();
    base = rx_cnt;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1; m_ignore = 1'b0;
    changed = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (tx_start !== 1'b0) changed = 1'b1;
    end
    chk("post_rst_no_start", 32'(changed), 32'd0);
    chk("post_rst_no_rx",    32'(rx_cnt),  32'(base));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
